// File: rtl/raycast_column_scheduler.sv
// Per-frame column sweep: generates ray angles by fixed-point accumulation (integer deg + thousandths),
// handshakes each angle with the ray unit, then forwards the clamped distance to the column drawer.
//
//   state  | meaning
//   IDLE   | waiting for frame_start
//   SETUP  | load column 0 and starting angle
//   RAY    | ray_req held until ray_ack
//   DRAW   | draw_req held until draw_ack
//   NEXT   | advance column and angle, or finish
//   DONE   | frame_done pulse, busy drops after
module raycast_column_scheduler #(
  parameter int NUM_COLS  = 160,
  parameter int HALF_FOV  = 30,
  parameter int STEP_INT  = 0,
  parameter int STEP_FRAC = 375
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [8:0]         player_angle,
  output logic               ray_req,
  output logic [8:0]         ray_angle_int,
  output logic [9:0]         ray_angle_frac,
  input  logic               ray_ack,
  input  logic signed [20:0] ray_dist,
  output logic               draw_req,
  output logic [7:0]         draw_col,
  output logic [20:0]        draw_dist,
  input  logic               draw_ack,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RAY, S_DRAW, S_NEXT, S_DONE
  } state_t;

  state_t     state;
  logic [8:0] angle_lat;

  logic [10:0] frac_sum;
  logic        carry;
  logic [9:0]  frac_next;
  logic [9:0]  int_sum;
  logic [8:0]  int_next;
  logic [9:0]  setup_sum;

  // 10-bit intermediates so the wrap compare sees the true sum before truncation
  always_comb begin
    frac_sum  = {1'b0, ray_angle_frac} + 11'(STEP_FRAC);
    carry     = (frac_sum >= 11'd1000);
    frac_next = carry ? 10'(frac_sum - 11'd1000) : frac_sum[9:0];
    int_sum   = {1'b0, ray_angle_int} + 10'(STEP_INT) + {9'd0, carry};
    int_next  = (int_sum >= 10'd360) ? 9'(int_sum - 10'd360) : int_sum[8:0];
    if (angle_lat < 9'(HALF_FOV))
      setup_sum = {1'b0, angle_lat} + 10'(360 - HALF_FOV);
    else
      setup_sum = {1'b0, angle_lat} - 10'(HALF_FOV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      angle_lat      <= '0;
      ray_req        <= 1'b0;
      ray_angle_int  <= '0;
      ray_angle_frac <= '0;
      draw_req       <= 1'b0;
      draw_col       <= '0;
      draw_dist      <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && state != S_IDLE)
        frame_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            angle_lat     <= player_angle;
            frame_overrun <= 1'b0;
            busy          <= 1'b1;
            state         <= S_SETUP;
          end
        end
        S_SETUP: begin
          draw_col       <= '0;
          ray_angle_frac <= '0;
          ray_angle_int  <= setup_sum[8:0];
          ray_req        <= 1'b1;
          state          <= S_RAY;
        end
        S_RAY: begin
          if (ray_ack) begin
            draw_dist <= ray_dist[20] ? '0 : $unsigned(ray_dist);
            ray_req   <= 1'b0;
            draw_req  <= 1'b1;
            state     <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (draw_ack) begin
            draw_req <= 1'b0;
            state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (draw_col == 8'(NUM_COLS - 1)) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            draw_col       <= draw_col + 8'd1;
            ray_angle_frac <= frac_next;
            ray_angle_int  <= int_next;
            ray_req        <= 1'b1;
            state          <= S_RAY;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raycast_column_scheduler.sv
// Bench for raycast_column_scheduler: protocol-level model with closed-form ray angles,
// per-cycle compare on the falling edge, plus literal checks of key columns and latencies.
module tb_raycast_column_scheduler;
  localparam int NC = 160, HF = 30, SI = 0, SF = 375;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_start = 1'b0;
  logic [8:0]         player_angle = '0;
  logic               ray_req;
  logic [8:0]         ray_angle_int;
  logic [9:0]         ray_angle_frac;
  logic               ray_ack = 1'b0;
  logic signed [20:0] ray_dist = '0;
  logic               draw_req;
  logic [7:0]         draw_col;
  logic [20:0]        draw_dist;
  logic               draw_ack = 1'b0;
  logic               busy, frame_done, frame_overrun;

  raycast_column_scheduler #(
    .NUM_COLS(NC), .HALF_FOV(HF), .STEP_INT(SI), .STEP_FRAC(SF)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .player_angle(player_angle),
    .ray_req(ray_req), .ray_angle_int(ray_angle_int), .ray_angle_frac(ray_angle_frac),
    .ray_ack(ray_ack), .ray_dist(ray_dist),
    .draw_req(draw_req), .draw_col(draw_col), .draw_dist(draw_dist), .draw_ack(draw_ack),
    .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Angle of column k in thousandths of a degree, straight from start angle plus k steps.
  function automatic int exp_milli(input int pa, input int k);
    int start;
    start = (pa >= HF) ? pa - HF : pa + 360 - HF;
    return (start * 1000 + k * (SI * 1000 + SF)) % 360000;
  endfunction

  // model: 0 idle, 1 setup, 2 waiting on ray, 3 waiting on draw, 4 advance, 5 done pulse
  int          m_phase = 0, m_col = 0, m_pa = 0;
  logic [20:0] m_dist = '0;
  logic        m_ovr = 1'b0;

  int n_done = 0, done_cyc = 0, st_cyc = 0, ray_hs = 0, draw_hs = 0;
  int cap_ang [0:NC-1];
  int cap_dist [0:NC-1];

  always @(negedge clk) begin
    chk("ray_req", ray_req, m_phase == 2);
    chk("draw_req", draw_req, m_phase == 3);
    chk("busy", busy, m_phase != 0);
    chk("frame_done", frame_done, m_phase == 5);
    chk("frame_overrun", frame_overrun, m_ovr);
    if (m_phase == 2) begin
      chk("ray_angle_milli", int'(ray_angle_int) * 1000 + int'(ray_angle_frac), exp_milli(m_pa, m_col));
      chk("col_in_ray", draw_col, m_col);
    end
    if (m_phase == 3) begin
      chk("draw_col", draw_col, m_col);
      chk("draw_dist", draw_dist, m_dist);
    end
    if (frame_done) begin n_done++; done_cyc = cyc; end
    if (ray_req && ray_ack) begin
      ray_hs++;
      cap_ang[m_col] = int'(ray_angle_int) * 1000 + int'(ray_angle_frac);
    end
    if (draw_req && draw_ack) begin
      draw_hs++;
      cap_dist[m_col] = int'(draw_dist);
    end
    if (reset) begin
      m_phase = 0;
      m_ovr   = 1'b0;
    end else begin
      if (frame_start && m_phase != 0) m_ovr = 1'b1;
      case (m_phase)
        0: if (frame_start) begin m_phase = 1; m_ovr = 1'b0; m_pa = int'(player_angle); end
        1: begin m_col = 0; m_phase = 2; end
        2: if (ray_ack) begin m_dist = (ray_dist < 0) ? '0 : ray_dist; m_phase = 3; end
        3: if (draw_ack) m_phase = 4;
        4: if (m_col == NC - 1) m_phase = 5; else begin m_col++; m_phase = 2; end
        default: m_phase = 0;
      endcase
    end
  end

  // ack_mode: 0 none, 1 tied high, 2 random 0-7 cycle delay, 3 tied high but draw held at column 100
  int ack_mode = 0;
  int rwait = -1, dwait = -1;
  always @(posedge clk) begin
    #1;
    ray_dist = (m_col == 3) ? -21'sd5 : 21'($urandom);
    case (ack_mode)
      1: begin ray_ack = 1'b1; draw_ack = 1'b1; end
      2: begin
        ray_ack = 1'b0; draw_ack = 1'b0;
        if (ray_req) begin
          if (rwait < 0) rwait = int'($urandom_range(0, 7));
          if (rwait == 0) begin ray_ack = 1'b1; rwait = -1; end else rwait--;
        end else rwait = -1;
        if (draw_req) begin
          if (dwait < 0) dwait = int'($urandom_range(0, 7));
          if (dwait == 0) begin draw_ack = 1'b1; dwait = -1; end else dwait--;
        end else dwait = -1;
      end
      3: begin ray_ack = 1'b1; draw_ack = (m_col != 100); end
      default: begin ray_ack = 1'b0; draw_ack = 1'b0; end
    endcase
  end

  task automatic start_frame(input logic [8:0] pa);
    @(posedge clk); #2;
    player_angle = pa; frame_start = 1'b1; st_cyc = cyc;
    ray_hs = 0; draw_hs = 0;
    @(posedge clk); #2;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n0;
    n0 = n_done;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (n_done != n0) return;
    end
    chk("frame_done_timeout", 0, 1);
  endtask

  task automatic wait_col(input int col, input int phase, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (m_col == col && m_phase == phase) return;
    end
    chk("wait_col_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ray_req"}, ray_req, 0);
    chk({tag, "_draw_req"}, draw_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, frame_overrun, 0);
    chk({tag, "_angle_int"}, ray_angle_int, 0);
    chk({tag, "_angle_frac"}, ray_angle_frac, 0);
    chk({tag, "_col"}, draw_col, 0);
    chk({tag, "_dist"}, draw_dist, 0);
  endtask

  initial begin
    int nd;
    // reset held with start and acks asserted
    reset = 1'b1; frame_start = 1'b1; player_angle = 9'd90; ack_mode = 1;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0; frame_start = 1'b0; ack_mode = 0;
    @(negedge clk); #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    #1 chk("idle_busy_after_reset", busy, 0);

    // nominal frame, immediate acks
    ack_mode = 1;
    start_frame(9'd90);
    wait_done(600);
    chk("done_latency", done_cyc - st_cyc, 482);
    chk("ray_handshakes", ray_hs, 160);
    chk("draw_handshakes", draw_hs, 160);
    chk("pa90_col0", cap_ang[0], 60000);
    chk("pa90_col1", cap_ang[1], 60375);
    chk("pa90_col8", cap_ang[8], 63000);
    chk("pa90_col159", cap_ang[159], 119625);

    // start below HALF_FOV with wrap through 360
    start_frame(9'd10);
    wait_done(600);
    chk("pa10_col0", cap_ang[0], 340000);
    chk("pa10_col53", cap_ang[53], 359875);
    chk("pa10_col54", cap_ang[54], 250);
    chk("pa10_col159", cap_ang[159], 39625);

    // random ack delays
    ack_mode = 2;
    start_frame(9'd200);
    wait_done(3500);
    chk("rand_ray_handshakes", ray_hs, 160);
    chk("rand_draw_handshakes", draw_hs, 160);
    chk("neg_dist_clamped", cap_dist[3], 0);
    chk("pa200_col159", cap_ang[159], 229625);

    // overrun: start and angle change mid-sweep
    ack_mode = 1;
    start_frame(9'd45);
    wait_col(40, 2, 400);
    @(posedge clk); #2 player_angle = 9'd300; frame_start = 1'b1;
    @(posedge clk); #2 frame_start = 1'b0;
    @(negedge clk); #1 chk("overrun_set", frame_overrun, 1);
    wait_done(600);
    chk("pa45_col0", cap_ang[0], 15000);
    chk("pa45_col159", cap_ang[159], 74625);
    repeat (2) @(negedge clk);
    #1 chk("overrun_sticky", frame_overrun, 1);
    start_frame(9'd90);
    @(negedge clk); #1 chk("overrun_cleared", frame_overrun, 0);
    wait_done(600);

    // reset while DRAW is stalled at column 100
    ack_mode = 3;
    start_frame(9'd90);
    wait_col(100, 3, 400);
    repeat (3) @(negedge clk);
    nd = n_done;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    ack_mode = 1;
    @(negedge clk); #1;
    check_zero("mid_reset");
    repeat (5) @(negedge clk);
    #1 chk("no_done_after_reset", n_done, nd);
    start_frame(9'd120);
    wait_done(600);
    chk("restart_latency", done_cyc - st_cyc, 482);
    chk("restart_col0", cap_ang[0], 90000);
    chk("restart_handshakes", ray_hs, 160);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
